// File: rtl/inst_queue.sv
// DEPTH-entry instruction prefetch queue feeding a registered decode instruction.
// Optional bypass of an empty queue is enabled with `define INST_QUEUE_BYPASS_EN.

`ifndef INST_MEM
`define INST_MEM 2'b00
`endif
`ifndef INST_OLD
`define INST_OLD 2'b01
`endif
`ifndef INST_NOP
`define INST_NOP 2'b10
`endif

module inst_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            rdata,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [1:0]                 inst_sel,
    input  logic                       flush,
    output logic [XLEN-1:0]            inst,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            sel_mem;
    logic            sel_old;
    logic            empty;
    logic            bypass;
    logic            pop;
    logic            push;

    assign rready  = (count < CW'(DEPTH));
    assign sel_mem = (inst_sel == `INST_MEM);
    assign sel_old = (inst_sel == `INST_OLD);
    assign empty   = (count == '0);

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = sel_mem && empty && rvalid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A word offered while full is dropped; a bypassed word never enters storage.
    assign pop  = sel_mem && !empty && !flush;
    assign push = rvalid && rready && !flush && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                inst       <= mem[rd_ptr];
                inst_valid <= 1'b1;
            end else if (bypass) begin
                inst       <= rdata;
                inst_valid <= 1'b1;
            end else if (!sel_old) begin
                // Empty INST_MEM, INST_NOP and unused encodings all issue a bubble.
                inst       <= NOP_WORD;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised self-checking bench for inst_queue against a queue-based reference model.
// Honours INST_QUEUE_BYPASS_EN the same way the design does.

`ifndef INST_MEM
`define INST_MEM 2'b00
`endif
`ifndef INST_OLD
`define INST_OLD 2'b01
`endif
`ifndef INST_NOP
`define INST_NOP 2'b10
`endif

module tb_inst_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [1:0]  inst_sel = `INST_NOP;
    logic        flush = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [2:0]  count;

    int errs   = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic [31:0] exp_inst = NOP;
    logic        exp_vld  = 1'b0;

    inst_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .inst_sel(inst_sel), .flush(flush), .inst(inst), .inst_valid(inst_valid),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string when);
        check({when, ".inst"},  inst, exp_inst);
        check({when, ".valid"}, 32'(inst_valid), 32'(exp_vld));
        check({when, ".count"}, 32'(count), 32'(q.size()));
    endtask

    // Reference: a word queue plus the last issued instruction.
    task automatic model_edge(input logic [31:0] d, input logic v, input logic [1:0] s,
                              input logic f);
        bit full;
        bit byp;
        if (f) begin
            q.delete();
            exp_inst = NOP;
            exp_vld  = 1'b0;
        end else begin
            full = (q.size() >= DEPTH);
            byp  = BYP && (s == `INST_MEM) && (q.size() == 0) && v;
            if (s == `INST_MEM && q.size() > 0) begin
                exp_inst = q.pop_front();
                exp_vld  = 1'b1;
            end else if (byp) begin
                exp_inst = d;
                exp_vld  = 1'b1;
            end else if (s != `INST_OLD) begin
                exp_inst = NOP;
                exp_vld  = 1'b0;
            end
            if (v && !full && !byp) q.push_back(d);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic [1:0] s,
                        input logic f);
        @(negedge clk);
        rdata = d; rvalid = v; inst_sel = s; flush = f;
        #1;
        check("rready", 32'(rready), 32'(q.size() < DEPTH));
        model_edge(d, v, s, f);
        @(posedge clk);
        #1;
        check_outputs("edge");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rdata = 32'hDEADBEEF; rvalid = 1'b1; inst_sel = `INST_MEM; flush = 1'b0;
        rst = 1'b1;
        q.delete();
        exp_inst = NOP;
        exp_vld  = 1'b0;
        #1;
        check("rst.rready", 32'(rready), 32'd1);
        check_outputs("rst");
        @(posedge clk);
        #1;
        check("rsthold.rready", 32'(rready), 32'd1);
        check_outputs("rsthold");
        @(negedge clk);
        rst = 1'b0;
        rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] stream [5];
        stream = '{32'd11, 32'd3, 32'hFFFFFFFC, 32'd4, 32'hFFFFFFF0};

        repeat (2) @(posedge clk);
        do_reset();

        foreach (stream[i]) step(stream[i], 1'b1, `INST_MEM, 1'b0);
        step('0, 1'b0, `INST_MEM, 1'b0);
        if (!BYP) begin
            check("stream.last", inst, 32'hFFFFFFF0);
        end

        repeat (2) step('0, 1'b0, `INST_OLD, 1'b0);
        repeat (2) step('0, 1'b0, `INST_NOP, 1'b0);

        for (int i = 0; i < 6; i++) step(32'h100 + i, 1'b1, `INST_NOP, 1'b0);
        check("full.count", 32'(count), 32'd4);
        check("full.rready", 32'(rready), 32'd0);
        for (int i = 0; i < 5; i++) step('0, 1'b0, `INST_MEM, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h200 + i, 1'b1, `INST_NOP, 1'b0);
        step(32'h203, 1'b1, `INST_OLD, 1'b0);
        for (int i = 0; i < 5; i++) step('0, 1'b0, `INST_MEM, 1'b0);

        for (int i = 0; i < 3; i++) step(32'h300 + i, 1'b1, `INST_NOP, 1'b0);
        step(32'h3FF, 1'b1, `INST_MEM, 1'b1);
        check("flush.inst", inst, NOP);
        check("flush.count", 32'(count), 32'd0);
        repeat (3) step('0, 1'b0, `INST_MEM, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                do_reset();
            end else begin
                step($urandom, ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 39) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
